// File: rtl/ascii_upper_arbiter.sv
// Two-requester, packet-level arbiter sharing one ASCII-to-uppercase converter with a registered output.
// Define CASE_STATS_EN to add the saturating conv_count / byte_count statistics.
module ascii_upper_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [7:0]       a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
`ifdef CASE_STATS_EN
  ,
  output logic [CNT_W-1:0] conv_count,
  output logic [CNT_W-1:0] byte_count
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_A = 2'd1, SERVE_B = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;  // requester that wins a tie in IDLE: 0 = A, 1 = B
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       out_src_q, out_src_d;
  logic       out_free, acc_a, acc_b, acc, sel_last;
  logic [7:0] conv_in, conv_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !ptr_q)) state_d = SERVE_A;
        else if (b_valid)                    state_d = SERVE_B;
      end
      SERVE_A: begin
        if (acc_a && a_last) begin
          state_d = IDLE;
          ptr_d   = 1'b1;
        end
      end
      SERVE_B: begin
        if (acc_b && b_last) begin
          state_d = IDLE;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies depend only on state and the output slot, never on the requester's own valid.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    a_ready  = (state_q == SERVE_A) && out_free;
    b_ready  = (state_q == SERVE_B) && out_free;
    busy     = (state_q != IDLE) || out_valid_q;
  end

  always_comb begin
    acc_a    = a_valid && a_ready;
    acc_b    = b_valid && b_ready;
    acc      = acc_a || acc_b;
    conv_in  = 8'h00;
    sel_last = 1'b0;
    case (state_q)
      SERVE_A: begin conv_in = a_data; sel_last = a_last; end
      SERVE_B: begin conv_in = b_data; sel_last = b_last; end
      default: ;
    endcase
    conv_out = (conv_in >= 8'h61 && conv_in <= 8'h7A) ? conv_in - 8'h20 : conv_in;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_out;
      out_last_d  = sel_last;
      out_src_d   = acc_b;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

`ifdef CASE_STATS_EN
  logic             chg_q, chg_d;
  logic             hs;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d, byte_cnt_q, byte_cnt_d;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q      <= 1'b0;
      conv_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      chg_q      <= chg_d;
      conv_cnt_q <= conv_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // chg_q travels with out_data so the count reflects the byte actually handed off.
  always_comb begin
    hs         = out_valid_q && out_ready;
    chg_d      = acc ? (conv_out != conv_in) : chg_q;
    byte_cnt_d = byte_cnt_q;
    conv_cnt_d = conv_cnt_q;
    if (hs && byte_cnt_q != '1)          byte_cnt_d = byte_cnt_q + ONE;
    if (hs && chg_q && conv_cnt_q != '1) conv_cnt_d = conv_cnt_q + ONE;
  end

  assign conv_count = conv_cnt_q;
  assign byte_count = byte_cnt_q;
`endif
endmodule
